// File: rtl/la_in_capture.sv
// la_in_capture
// Samples the logic-analyzer input bus every cycle and watches for a masked
// trigger pattern. Each rising edge of a match (while armed) stores the sampled
// bus in a small snapshot FIFO. The head snapshot is streamed out LSW first as
// WORD_W-bit words over a valid/ready interface so firmware can read it back.
module la_in_capture #(
  parameter int LA_W   = 128,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     sys_clk,
  input  logic                     RSTB,
  input  logic [LA_W-1:0]          la_data_in,
  input  logic                     arm,
  input  logic [LA_W-1:0]          trig_mask,
  input  logic [LA_W-1:0]          trig_value,
  output logic [WORD_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     rd_last,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int NWORDS = LA_W / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Sampled bus and the registered match flag used for edge detection.
  logic [LA_W-1:0]   la_q;
  logic              match;
  logic              match_q;
  logic              cap;

  // Snapshot storage.
  logic [LA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LA_W-1:0]   head;
  logic [CNT_W-1:0]  count_next;
  logic              full;
  logic              wr_en;
  logic              drop;

  // Readout state.
  state_t            state_q;
  state_t            state_d;
  logic [IDX_W-1:0]  word_idx;
  logic [IDX_W-1:0]  word_idx_d;
  logic              handshake;
  logic              pop;

  // A snapshot is taken only on the first cycle of a match, so a held pattern
  // produces one capture rather than one per cycle.
  assign match = (((la_q ^ trig_value) & trig_mask) == '0);
  assign cap   = arm & match & ~match_q;

  // The head word leaves on a handshake; the final word of a snapshot frees
  // its FIFO slot.
  assign handshake = rd_valid & rd_ready;
  assign pop       = handshake & rd_last;

  // When full, a pop on the same edge frees the slot the new snapshot needs.
  assign full  = (fifo_count == FULL_CNT);
  assign wr_en = cap & (~full | pop);
  assign drop  = cap & ~wr_en;

  assign head = mem[rd_ptr];

  // Register the bus and the match flag every cycle, regardless of arm.
  always_ff @(posedge sys_clk or negedge RSTB) begin
    if (!RSTB) begin
      la_q    <= '0;
      match_q <= 1'b0;
    end else begin
      la_q    <= la_data_in;
      match_q <= match;
    end
  end

  // Snapshot storage needs no reset; the pointers and count define validity.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= la_q;
    end
  end

  // Occupancy after this edge: writes and pops on the same edge cancel.
  always_comb begin
    count_next = fifo_count;
    if (wr_en && !pop) begin
      count_next = fifo_count + CNT_W'(1);
    end else if (pop && !wr_en) begin
      count_next = fifo_count - CNT_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge sys_clk or negedge RSTB) begin
    if (!RSTB) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count <= count_next;
    end
  end

  // Sticky drop flag; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge sys_clk or negedge RSTB) begin
    if (!RSTB) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // Readout state register and word pointer.
  always_ff @(posedge sys_clk or negedge RSTB) begin
    if (!RSTB) begin
      state_q  <= IDLE;
      word_idx <= '0;
    end else begin
      state_q  <= state_d;
      word_idx <= word_idx_d;
    end
  end

  // Output decode: driven purely from state so reset clears them at once and
  // the presented word cannot change until it is accepted.
  always_comb begin
    rd_valid = 1'b0;
    rd_last  = 1'b0;
    rd_data  = '0;
    if (state_q == SEND) begin
      rd_valid = 1'b1;
      rd_last  = (word_idx == LAST_IDX);
      for (int i = 0; i < NWORDS; i++) begin
        if (word_idx == IDX_W'(i)) begin
          rd_data = head[i*WORD_W +: WORD_W];
        end
      end
    end
  end

  // Next-state logic: start sending once a snapshot is stored, and continue
  // straight into the next snapshot without an idle cycle if one remains.
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx;
    case (state_q)
      IDLE: begin
        word_idx_d = '0;
        if (fifo_count != '0) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (pop) begin
          word_idx_d = '0;
          if (count_next == '0) begin
            state_d = IDLE;
          end
        end else if (handshake) begin
          word_idx_d = word_idx + IDX_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        word_idx_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_la_in_capture.sv
// tb_la_in_capture
// Directed bench for la_in_capture. Stimulus pushes the expected readout words
// of each snapshot into a queue; a monitor on the falling edge compares every
// presented word with the queue head and pops it on a handshake.
module tb_la_in_capture;

  localparam int LA_W   = 128;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 4;

  logic              sys_clk = 1'b0;
  logic              RSTB;
  logic [LA_W-1:0]   la_data_in;
  logic              arm;
  logic [LA_W-1:0]   trig_mask;
  logic [LA_W-1:0]   trig_value;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              rd_ready;
  logic [2:0]        fifo_count;
  logic              overflow;
  logic              clr_ovf;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   errors     = 0;
  int   words_seen = 0;

  la_in_capture #(.LA_W(LA_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .sys_clk    (sys_clk),
    .RSTB       (RSTB),
    .la_data_in (la_data_in),
    .arm        (arm),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_last    (rd_last),
    .rd_ready   (rd_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  // Free-running 100 MHz clock.
  always #5 sys_clk = ~sys_clk;

  // Hand-written bus vectors; low byte 5A matches the trigger, word order is
  // {word3, word2, word1, word0}.
  function automatic logic [127:0] vec(input int k);
    case (k)
      0:  vec = {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 32'h9ABC_DE5A};
      1:  vec = {32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_325A};
      2:  vec = {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A05A};
      3:  vec = {32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hB0B0_B05A};
      4:  vec = {32'hC3C3_C3C3, 32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C05A};
      5:  vec = {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D05A};
      6:  vec = {32'hE3E3_E3E3, 32'hE2E2_E2E2, 32'hE1E1_E1E1, 32'hE0E0_E05A};
      7:  vec = {32'h7000_0003, 32'h7000_0002, 32'h7000_0001, 32'h7000_005A};
      8:  vec = {32'h8000_0003, 32'h8000_0002, 32'h8000_0001, 32'h8000_005A};
      9:  vec = {32'h9000_0003, 32'h9000_0002, 32'h9000_0001, 32'h9000_005A};
      10: vec = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_005A};
      11: vec = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_005A};
      12: vec = {32'h0C0C_0003, 32'h0C0C_0002, 32'h0C0C_0001, 32'h0C0C_005A};
      13: vec = {32'h0D0D_0003, 32'h0D0D_0002, 32'h0D0D_0001, 32'h0D0D_005A};
      14: vec = {32'h0E0E_0003, 32'h0E0E_0002, 32'h0E0E_0001, 32'h0E0E_005A};
      15: vec = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_115A};
      default: vec = '0;
    endcase
  endfunction

  // One comparison: count it, report it if it differs.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Queue the four readout words of a snapshot, least significant first.
  task automatic pushSnapshot(input logic [127:0] la);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.data = la[i*32 +: 32];
      e.last = (i == 3);
      exp_q.push_back(e);
    end
  endtask

  // Drive a bus value for exactly one sampling edge, then return to idle.
  task automatic applyStimulus(input logic [127:0] la, input bit expect_capture);
    @(posedge sys_clk);
    #1;
    la_data_in = la;
    if (expect_capture) pushSnapshot(la);
    @(posedge sys_clk);
    #1;
    la_data_in = '0;
  endtask

  // Wait (bounded) until every expected word has been read, then confirm idle.
  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge sys_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_drain_timeout: got %0d words left expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput({name, "_idle_valid"}, 32'(rd_valid), 32'd0);
    checkOutput({name, "_idle_count"}, 32'(fifo_count), 32'd0);
  endtask

  // Scoreboard monitor: compare each presented word to the queue head.
  always @(negedge sys_clk) begin
    exp_t e;
    if (RSTB === 1'b1 && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got %0h expected no word", rd_data);
      end else begin
        e = exp_q[0];
        checkOutput("rd_data", rd_data, e.data);
        checkOutput("rd_last", 32'(rd_last), 32'(e.last));
        if (rd_ready) begin
          void'(exp_q.pop_front());
          words_seen++;
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ws;
    int bubbles;
    RSTB       = 1'b0;
    la_data_in = '0;
    arm        = 1'b0;
    trig_mask  = 128'hFF;
    trig_value = 128'h5A;
    rd_ready   = 1'b1;
    clr_ovf    = 1'b0;

    // Reset state.
    #12;
    checkOutput("rst_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_last", 32'(rd_last), 32'd0);
    checkOutput("rst_data", rd_data, 32'd0);
    checkOutput("rst_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    @(posedge sys_clk);
    #1;
    RSTB = 1'b1;

    // Disarmed: a matching value must not be captured.
    $display("[TB] disarmed match");
    applyStimulus(vec(0), 1'b0);
    repeat (4) @(posedge sys_clk);
    #1;
    checkOutput("disarmed_count", 32'(fifo_count), 32'd0);
    arm = 1'b1;

    // Single snapshot, four words LSW first.
    $display("[TB] single snapshot");
    applyStimulus(vec(1), 1'b1);
    @(posedge sys_clk);
    #1;
    checkOutput("t1_count_one", 32'(fifo_count), 32'd1);
    waitDrain("t1");

    // Held match gives exactly one snapshot.
    $display("[TB] held match");
    ws = words_seen;
    @(posedge sys_clk);
    #1;
    la_data_in = vec(15);
    pushSnapshot(vec(15));
    repeat (10) @(posedge sys_clk);
    #1;
    la_data_in = '0;
    waitDrain("t2");
    checkOutput("t2_words", 32'(words_seen - ws), 32'd4);

    // Five triggers with the consumer stalled: fifth dropped.
    $display("[TB] overflow");
    rd_ready = 1'b0;
    for (int k = 2; k <= 6; k++) applyStimulus(vec(k), k < 6);
    repeat (2) @(posedge sys_clk);
    #1;
    checkOutput("t3_count_full", 32'(fifo_count), 32'd4);
    checkOutput("t3_overflow_set", 32'(overflow), 32'd1);
    rd_ready = 1'b1;
    waitDrain("t3");
    checkOutput("t3_overflow_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    @(posedge sys_clk);
    #1;
    clr_ovf = 1'b0;
    checkOutput("t3_overflow_clear", 32'(overflow), 32'd0);

    // Full FIFO, new capture on the same edge as the last-word pop.
    $display("[TB] capture on pop edge");
    rd_ready = 1'b0;
    for (int k = 7; k <= 10; k++) applyStimulus(vec(k), 1'b1);
    repeat (2) @(posedge sys_clk);
    #1;
    checkOutput("t4_count_full", 32'(fifo_count), 32'd4);
    rd_ready = 1'b1;
    @(posedge sys_clk);
    applyStimulus(vec(11), 1'b1);
    @(posedge sys_clk);
    #1;
    checkOutput("t4_count_held", 32'(fifo_count), 32'd4);
    checkOutput("t4_overflow", 32'(overflow), 32'd0);
    waitDrain("t4");

    // Ready toggling every cycle across two back-to-back snapshots.
    $display("[TB] toggled ready");
    rd_ready = 1'b0;
    applyStimulus(vec(12), 1'b1);
    applyStimulus(vec(13), 1'b1);
    repeat (2) @(posedge sys_clk);
    ws      = words_seen;
    bubbles = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge sys_clk);
      #1;
      rd_ready = ~rd_ready;
      @(negedge sys_clk);
      if (exp_q.size() != 0 && !rd_valid) bubbles++;
      if (exp_q.size() == 0) break;
    end
    checkOutput("t5_bubbles", 32'(bubbles), 32'd0);
    checkOutput("t5_words", 32'(words_seen - ws), 32'd8);
    rd_ready = 1'b1;
    waitDrain("t5");

    // Reset during word 2 of a readout.
    $display("[TB] reset mid-readout");
    rd_ready = 1'b1;
    applyStimulus(vec(14), 1'b1);
    repeat (4) @(posedge sys_clk);
    #1;
    RSTB = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("t6_valid_drop", 32'(rd_valid), 32'd0);
    checkOutput("t6_count_clear", 32'(fifo_count), 32'd0);
    checkOutput("t6_last_clear", 32'(rd_last), 32'd0);
    @(posedge sys_clk);
    #1;
    RSTB = 1'b1;
    ws = words_seen;
    repeat (10) @(posedge sys_clk);
    #1;
    checkOutput("t6_no_stale_words", 32'(words_seen - ws), 32'd0);
    checkOutput("t6_idle_valid", 32'(rd_valid), 32'd0);
    checkOutput("t6_idle_count", 32'(fifo_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
